trigger_hit_decoder: RTL and testbench

//  Decoder side of the trigger-info channel-index path: accepts a stream of encoded channel

---
 rtl/trig_info_pkg.sv | 9 +
 rtl/trig_hit_window_timer.sv | 19 +
 rtl/trigger_hit_decoder.sv | 74 +++++++
 tb/tb_trigger_hit_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/trig_info_pkg.sv
// trig_info_pkg: shared trigger-info types and defaults for the channel-index encoder/decoder pair.
package trig_info_pkg;
  localparam int NUM_CH_DEF = 128;
  localparam int IDX_W_DEF = 9;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} trig_state_t;
  typedef logic [NUM_CH_DEF-1:0] hit_map_t;
  typedef logic [CNT_W-1:0] hit_count_t;
endpackage

// File: rtl/trig_hit_window_timer.sv
// trig_hit_window_timer: collection-window counter, flags expiry on its last window cycle.
module trig_hit_window_timer #(
  parameter int WINDOW_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int TW = (WINDOW_CYC > 2) ? $clog2(WINDOW_CYC) : 1;
  logic [TW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end
  assign expired = cnt == TW'(WINDOW_CYC - 1);
endmodule

// File: rtl/trigger_hit_decoder.sv
// trigger_hit_decoder: rebuilds per-event hit map from channel indices; TRIG_HIT_DEC_FIRST_IDX_EN adds first_idx output.
module trigger_hit_decoder
  import trig_info_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int WINDOW_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx_in,
  input  logic              idx_valid,
  input  logic              idx_last,
  output logic              idx_ready,
  output logic [NUM_CH-1:0] map_out,
  output hit_count_t        map_count,
  output logic              map_valid,
  input  logic              map_ready,
`ifdef TRIG_HIT_DEC_FIRST_IDX_EN
  output logic [IDX_W-1:0]  first_idx,
`endif
  output logic              err_oor
);
  localparam int CH_W = $clog2(NUM_CH);
  trig_state_t state, state_nx;
  logic accept, in_range, is_new, expired, take;
  logic [CH_W-1:0] ch;
  assign idx_ready = state != HOLD;
  assign map_valid = state == HOLD;
  assign accept = idx_valid & idx_ready;
  assign take = map_valid & map_ready;
  assign in_range = idx_in < IDX_W'(NUM_CH);
  assign ch = idx_in[CH_W-1:0];
  assign is_new = in_range & ~map_out[ch];
  trig_hit_window_timer #(.WINDOW_CYC(WINDOW_CYC)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state != COLLECT),
    .inc(state == COLLECT),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE && accept) state_nx = idx_last ? HOLD : COLLECT;
    else if (state == COLLECT && ((accept && idx_last) || expired)) state_nx = HOLD;
    else if (take) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_out <= '0;
      map_count <= '0;
      err_oor <= 1'b0;
    end else if (take) begin
      map_out <= '0;
      map_count <= '0;
    end else if (accept) begin
      if (in_range) map_out[ch] <= 1'b1;
      if (is_new) map_count <= map_count + 1'b1;
      if (!in_range) err_oor <= 1'b1;
    end
  end
`ifdef TRIG_HIT_DEC_FIRST_IDX_EN
  // Running minimum over accepted indices; an empty map means nothing recorded yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) first_idx <= '0;
    else if (take) first_idx <= '0;
    else if (accept && in_range && (map_count == '0 || idx_in < first_idx)) first_idx <= idx_in;
  end
`endif
endmodule

// File: tb/tb_trigger_hit_decoder.sv
// tb_trigger_hit_decoder: directed and randomized checks of trigger_hit_decoder against an event-level model.
module tb_trigger_hit_decoder;
  logic clk, rst_n, idx_valid, idx_last, idx_ready, map_valid, map_ready, err_oor;
  logic [8:0] idx_in;
  logic [127:0] map_out, exp_map;
  logic [7:0] map_count;
  logic [8:0] first_idx;
  logic exp_err;
  int errors = 0, checks = 0;

  trigger_hit_decoder dut (
    .clk(clk), .rst_n(rst_n), .idx_in(idx_in), .idx_valid(idx_valid), .idx_last(idx_last),
    .idx_ready(idx_ready), .map_out(map_out), .map_count(map_count), .map_valid(map_valid),
    .map_ready(map_ready),
`ifdef TRIG_HIT_DEC_FIRST_IDX_EN
    .first_idx(first_idx),
`endif
    .err_oor(err_oor)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idx(input logic [8:0] i, input logic l);
    idx_in = i; idx_valid = 1; idx_last = l;
    step();
    idx_valid = 0; idx_last = 0;
  endtask

  task automatic consume();
    map_ready = 1;
    step();
    map_ready = 0;
  endtask

  function automatic int lowest(input logic [127:0] m);
    for (int i = 0; i < 128; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic test_reset();
    rst_n = 0; idx_valid = 0; idx_last = 0; idx_in = 0; map_ready = 0; exp_err = 0;
    repeat (3) step();
    @(negedge clk) rst_n = 1;
    step();
    checks++; if (idx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", idx_ready); end
    checks++; if (map_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", map_valid); end
    checks++; if (map_out !== 128'd0) begin errors++; $display("FAIL reset_map got=%h exp=0", map_out); end
    checks++; if (map_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", map_count); end
    checks++; if (err_oor !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_oor); end
  endtask

  task automatic test_basic();
    exp_map = '0; exp_map[5] = 1; exp_map[17] = 1; exp_map[127] = 1;
    drive_idx(5, 0); drive_idx(17, 0);
    checks++; if (map_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", map_valid); end
    drive_idx(127, 1);
    checks++; if (map_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", map_valid); end
    checks++; if (map_out !== exp_map) begin errors++; $display("FAIL basic_map got=%h exp=%h", map_out, exp_map); end
    checks++; if (map_count !== 8'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", map_count); end
    checks++; if (idx_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready got=%b exp=0", idx_ready); end
    consume();
    checks++; if (map_valid !== 1'b0) begin errors++; $display("FAIL basic_release got=%b exp=0", map_valid); end
  endtask

  task automatic test_dup();
    exp_map = '0; exp_map[9] = 1;
    drive_idx(9, 0); drive_idx(9, 0); drive_idx(9, 1);
    checks++; if (map_out !== exp_map) begin errors++; $display("FAIL dup_map got=%h exp=%h", map_out, exp_map); end
    checks++; if (map_count !== 8'd1) begin errors++; $display("FAIL dup_count got=%0d exp=1", map_count); end
    consume();
  endtask

  task automatic test_oor();
    exp_map = '0; exp_map[3] = 1; exp_err = 1;
    drive_idx(200, 0);
    checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_err got=%b exp=1", err_oor); end
    drive_idx(3, 1);
    checks++; if (map_out !== exp_map) begin errors++; $display("FAIL oor_map got=%h exp=%h", map_out, exp_map); end
    checks++; if (map_count !== 8'd1) begin errors++; $display("FAIL oor_count got=%0d exp=1", map_count); end
    consume();
    drive_idx(300, 1);
    checks++; if (map_valid !== 1'b1 || map_out !== 128'd0 || map_count !== 8'd0) begin
      errors++; $display("FAIL oor_only got valid=%b map=%h cnt=%0d exp valid=1 map=0 cnt=0", map_valid, map_out, map_count);
    end
    consume();
    checks++; if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_sticky got=%b exp=1", err_oor); end
  endtask

  task automatic test_timeout();
    int n;
    exp_map = '0; exp_map[40] = 1;
    drive_idx(40, 0);
    n = 0;
    while (!map_valid && n < 40) begin step(); n++; end
    checks++; if (n !== 16) begin errors++; $display("FAIL timeout_cycles got=%0d exp=16", n); end
    checks++; if (map_out !== exp_map || map_count !== 8'd1) begin
      errors++; $display("FAIL timeout_map got map=%h cnt=%0d exp map=%h cnt=1", map_out, map_count, exp_map);
    end
    consume();
    exp_map[41] = 1;
    drive_idx(40, 0);
    repeat (15) step();
    checks++; if (map_valid !== 1'b0) begin errors++; $display("FAIL edge_early got=%b exp=0", map_valid); end
    drive_idx(41, 0);
    checks++; if (map_valid !== 1'b1 || map_out !== exp_map || map_count !== 8'd2) begin
      errors++; $display("FAIL edge_include got valid=%b map=%h cnt=%0d exp valid=1 map=%h cnt=2", map_valid, map_out, map_count, exp_map);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    exp_map = '0; exp_map[12] = 1;
    drive_idx(12, 1);
    idx_valid = 1; idx_in = 13; idx_last = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (idx_ready !== 1'b0 || map_valid !== 1'b1 || map_out !== exp_map) begin
        errors++; $display("FAIL stall_%0d got ready=%b valid=%b map=%h exp ready=0 valid=1 map=%h", k, idx_ready, map_valid, map_out, exp_map);
      end
    end
    map_ready = 1;
    step();
    map_ready = 0;
    checks++; if (map_valid !== 1'b0 || idx_ready !== 1'b1) begin
      errors++; $display("FAIL bubble got valid=%b ready=%b exp valid=0 ready=1", map_valid, idx_ready);
    end
    step();
    idx_valid = 0; idx_last = 0;
    exp_map = '0; exp_map[13] = 1;
    checks++; if (map_valid !== 1'b1 || map_out !== exp_map || map_count !== 8'd1) begin
      errors++; $display("FAIL next_event got valid=%b map=%h cnt=%0d exp valid=1 map=%h cnt=1", map_valid, map_out, map_count, exp_map);
    end
    consume();
  endtask

  task automatic test_random();
    int n, idx;
    for (int e = 0; e < 40; e++) begin
      exp_map = '0;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        idx = ($urandom_range(0, 9) == 0) ? $urandom_range(128, 511) : $urandom_range(0, 127);
        if (idx < 128) exp_map[idx] = 1; else exp_err = 1;
        if (k > 0 && $urandom_range(0, 2) == 0) step();
        drive_idx(9'(idx), k == n - 1);
        if (k == 0 && n > 1 && $urandom_range(0, 1) == 1) begin
          if (idx < 128) exp_map[idx] = 1;
          drive_idx(9'(idx), 0);
        end
      end
      repeat ($urandom_range(0, 3)) step();
      checks++; if (map_valid !== 1'b1 || map_out !== exp_map) begin
        errors++; $display("FAIL rand_map_%0d got valid=%b map=%h exp valid=1 map=%h", e, map_valid, map_out, exp_map);
      end
      checks++; if (map_count !== 8'($countones(exp_map))) begin
        errors++; $display("FAIL rand_count_%0d got=%0d exp=%0d", e, map_count, $countones(exp_map));
      end
      checks++; if (err_oor !== exp_err) begin errors++; $display("FAIL rand_err_%0d got=%b exp=%b", e, err_oor, exp_err); end
`ifdef TRIG_HIT_DEC_FIRST_IDX_EN
      checks++; if (first_idx !== 9'(lowest(exp_map))) begin
        errors++; $display("FAIL rand_first_%0d got=%0d exp=%0d", e, first_idx, lowest(exp_map));
      end
`endif
      consume();
      checks++; if (map_valid !== 1'b0 || map_count !== 8'd0) begin
        errors++; $display("FAIL rand_clear_%0d got valid=%b cnt=%0d exp valid=0 cnt=0", e, map_valid, map_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_idx(200, 0);
    drive_idx(8, 0);
    #2 rst_n = 0;
    #1;
    exp_err = 0;
    checks++; if (map_out !== 128'd0 || map_count !== 8'd0 || map_valid !== 1'b0 || err_oor !== exp_err) begin
      errors++; $display("FAIL mid_reset got map=%h cnt=%0d valid=%b err=%b exp all 0", map_out, map_count, map_valid, err_oor);
    end
    @(negedge clk) rst_n = 1;
    repeat (20) begin
      step();
      checks++; if (map_valid !== 1'b0 || idx_ready !== 1'b1) begin
        errors++; $display("FAIL mid_idle got valid=%b ready=%b exp valid=0 ready=1", map_valid, idx_ready);
      end
    end
    exp_map = '0; exp_map[100] = 1;
    drive_idx(100, 1);
    checks++; if (map_valid !== 1'b1 || map_out !== exp_map || map_count !== 8'd1) begin
      errors++; $display("FAIL mid_after got valid=%b map=%h cnt=%0d exp valid=1 map=%h cnt=1", map_valid, map_out, map_count, exp_map);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dup();
    test_oor();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
